multdiv_controller: RTL and testbench
=====================================

# multdiv_controller

Sequences the shared multi-cycle multiply/divide unit for the 5-stage pipeline. Captures a MULT or DIV issued from the execute stage, drives the unit's control pulse and held operands, and waits for its ready flag or a timeout. It then holds the result until the writeback port accepts it. It produces the `mult_operation_underway` and `div_operation_underway` stall signals consumed by decode.

## Interface
- `MAX_CYCLES`, default 40: BUSY cycles allowed before timeout abort. Legal range 1–255.
- `MULT_EXC_CODE`, default 4: status value written on a mult exception or timeout.
- `DIV_EXC_CODE`, default 5: status value written on a div exception or timeout.
- `STATUS_REG`, default 30: destination register used for exception writes.

Ports:
- `clock` in 1: single clock; everything rises on its edge.
- `reset` in 1: synchronous, active-low; sampled on `clock`.
- `start_mult` in 1: execute stage has a MULT this cycle.
- `start_div` in 1: execute stage has a DIV this cycle.
- `operand_A`, `operand_B` in 32: source operands, valid with a start.
- `rd_in` in 5: destination register of the issuing instruction.
- `md_ctrl_MULT`, `md_ctrl_DIV` out 1: one-cycle start pulses to the multdiv unit.
- `md_operand_A`, `md_operand_B` out 32: registered operands, held stable while BUSY.
- `md_result` in 32: multdiv unit result.
- `md_exception` in 1: overflow or divide-by-zero; valid with ready.
- `md_resultRDY` in 1: unit result valid for one cycle.
- `mult_operation_underway`, `div_operation_underway` out 1: stall requests.
- `wb_valid` out 1: result pending for writeback.
- `wb_data` out 32: write data.
- `wb_rd` out 5: write register.
- `wb_accept` in 1: writeback consumed `wb_data` this cycle.
- `timeout` out 1: sticky flag; set on any timeout, cleared only by reset.

## Operation
- **States:** IDLE, BUSY, DONE. Internal registers:
  - `op` (0 = mult, 1 = div)
  - `rd_q`
  - 8-bit `count`
- **IDLE with a start:**
  - Latch the operands into `md_operand_*`, latch `rd_in` into `rd_q`, set `op`, clear `count`; go to BUSY.
  - If `start_mult` and `start_div` are both high, MULT wins and the DIV is dropped.
- **IDLE otherwise:** `md_resultRDY` is ignored.
- **BUSY:**
  - The first BUSY cycle pulses `md_ctrl_MULT` or `md_ctrl_DIV` (per `op`) for exactly one cycle.
  - `count` increments every BUSY cycle.
  - If `md_resultRDY` is high, capture the result and go to DONE:
    - `md_exception` = 0: `wb_data` = `md_result`, `wb_rd` = `rd_q`.
    - `md_exception` = 1: `wb_data` = `MULT_EXC_CODE` or `DIV_EXC_CODE` (per `op`), `wb_rd` = `STATUS_REG`.
  - Otherwise, if `count` == `MAX_CYCLES` − 1: timeout. Load the exception write as above, set `timeout`, go to DONE.
  - If `md_resultRDY` coincides with the timeout cycle, ready wins and `timeout` is not set.
  - Starts are ignored while BUSY or DONE. Decode is stalled, so a start in these states is a protocol error and is dropped silently.
- **DONE:**
  - `wb_valid` = 1; `wb_data` and `wb_rd` are held.
  - `wb_accept` → IDLE on the next edge. With no accept, stay in DONE indefinitely.
- **Stall outputs:**
  - `mult_operation_underway` = (`op` == 0 && state != IDLE) || (IDLE && `start_mult`).
  - `div_operation_underway` = (`op` == 1 && state != IDLE) || (IDLE && `start_div` && !`start_mult`).
  - Both are combinational in the issue cycle; they are never high simultaneously.
- **Reset (reset == 0 at an edge), from any state:**
  - Go to IDLE.
  - All registered outputs become 0: `md_operand_*`, `wb_*`, `timeout`, `count`, `op`, `rd_q`.
  - Control pulses become 0.
  - An in-flight operation is abandoned; a late `md_resultRDY` lands in IDLE and is ignored.

## Timing
- **Cycle 0:** start sampled in IDLE; underway high combinationally.
- **Cycle 1:** BUSY; `md_ctrl_*` pulse; operands already valid on `md_operand_*`.
- **Cycle 1 + k:** `md_resultRDY` seen in BUSY.
- **Cycle 2 + k:** DONE; `wb_valid` high.
- **Retire:** `wb_accept` in the first DONE cycle means IDLE one cycle later.
- **Minimum latency:** start to `wb_valid` is 2 cycles (ready in the pulse cycle).
- **Timeout:** the last BUSY cycle is cycle `MAX_CYCLES`; DONE follows at cycle `MAX_CYCLES` + 1.
- **Underway:** stays high through the cycle in which `wb_accept` is sampled, and drops the following cycle.
- **Back-to-back:** a new start is accepted the first IDLE cycle after retire.

## Test plan
- **Mult:** reset, `start_mult` with A=6, B=7, `rd_in`=3; ready with 42 at cycle 33 → `md_ctrl_MULT` pulse at cycle 1 only; `wb_valid` at cycle 34 with `wb_data`=42, `wb_rd`=3; `mult_operation_underway` high cycles 0–34 with accept at 34.
- **Div by zero:** `start_div`, B=0; `md_exception` with ready at cycle 5 → `wb_data`=5, `wb_rd`=30; `div_operation_underway` high throughout; `timeout` stays 0.
- **Timeout:** `MAX_CYCLES`=40, mult, never ready → DONE at cycle 41 with `wb_data`=4, `wb_rd`=30, `timeout`=1 (sticky after retire); ready at cycle 40 in a second run → normal result, `timeout` unchanged.
- **Writeback backpressure:** hold `wb_accept` low 10 cycles in DONE → `wb_*` stable, underway high; accept → IDLE next cycle; an immediate new `start_mult` is accepted.
- **Simultaneous/illegal starts:** `start_mult` and `start_div` together → only `md_ctrl_MULT` pulses, only mult underway; `start_div` during BUSY → no effect on `op`, `rd_q` or operands.
- **Reset mid-op:** reset low at cycle 10 of BUSY → next cycle all outputs 0 and state IDLE; ready at cycle 15 → no `wb_valid`.

Source files
------------

// File: rtl/multdiv_controller.sv
// Issue/complete sequencer for the shared multi-cycle multiply/divide unit.
// Holds operands while the unit works, then holds the result until writeback takes it.
module multdiv_controller #(
    parameter int MAX_CYCLES    = 40,
    parameter int MULT_EXC_CODE = 4,
    parameter int DIV_EXC_CODE  = 5,
    parameter int STATUS_REG    = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] operand_A,
    input  logic [31:0] operand_B,
    input  logic [4:0]  rd_in,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    output logic [31:0] md_operand_A,
    output logic [31:0] md_operand_B,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        mult_operation_underway,
    output logic        div_operation_underway,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    input  logic        wb_accept,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] LAST_COUNT = 8'(MAX_CYCLES - 1);
    localparam logic [4:0] STATUS_RD  = 5'(STATUS_REG);

    state_t      state;
    logic        op;
    logic [4:0]  rd_q;
    logic [7:0]  count;

    function automatic logic [31:0] exc_code(input logic is_div);
        return is_div ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            op           <= 1'b0;
            rd_q         <= '0;
            count        <= '0;
            md_ctrl_MULT <= 1'b0;
            md_ctrl_DIV  <= 1'b0;
            md_operand_A <= '0;
            md_operand_B <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            timeout      <= 1'b0;
        end else begin
            md_ctrl_MULT <= 1'b0;
            md_ctrl_DIV  <= 1'b0;
            case (state)
                IDLE: begin
                    // MULT takes priority when both starts arrive together
                    if (start_mult || start_div) begin
                        md_operand_A <= operand_A;
                        md_operand_B <= operand_B;
                        rd_q         <= rd_in;
                        op           <= !start_mult;
                        md_ctrl_MULT <= start_mult;
                        md_ctrl_DIV  <= !start_mult;
                        count        <= '0;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    count <= count + 8'd1;
                    if (md_resultRDY) begin
                        state    <= DONE;
                        wb_valid <= 1'b1;
                        if (md_exception) begin
                            wb_data <= exc_code(op);
                            wb_rd   <= STATUS_RD;
                        end else begin
                            wb_data <= md_result;
                            wb_rd   <= rd_q;
                        end
                    end else if (count == LAST_COUNT) begin
                        state    <= DONE;
                        wb_valid <= 1'b1;
                        wb_data  <= exc_code(op);
                        wb_rd    <= STATUS_RD;
                        timeout  <= 1'b1;
                    end
                end
                DONE: begin
                    if (wb_accept) begin
                        wb_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall requests must rise in the issue cycle itself, hence the start terms
    assign mult_operation_underway = ((state != IDLE) && !op) ||
                                     ((state == IDLE) && start_mult);
    assign div_operation_underway  = ((state != IDLE) && op) ||
                                     ((state == IDLE) && start_div && !start_mult);

endmodule

// File: tb/tb_multdiv_controller.sv
// Bench for multdiv_controller: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_multdiv_controller;

    localparam int MAXC = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start_mult = 1'b0, start_div = 1'b0;
    logic [31:0] operand_A = '0, operand_B = '0;
    logic [4:0]  rd_in = '0;
    logic        md_ctrl_MULT, md_ctrl_DIV;
    logic [31:0] md_operand_A, md_operand_B;
    logic [31:0] md_result = '0;
    logic        md_exception = 1'b0, md_resultRDY = 1'b0;
    logic        mult_operation_underway, div_operation_underway;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_accept = 1'b0;
    logic        timeout;

    multdiv_controller #(.MAX_CYCLES(MAXC)) dut (
        .clock(clock), .reset(reset),
        .start_mult(start_mult), .start_div(start_div),
        .operand_A(operand_A), .operand_B(operand_B), .rd_in(rd_in),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
        .md_operand_A(md_operand_A), .md_operand_B(md_operand_B),
        .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
        .mult_operation_underway(mult_operation_underway),
        .div_operation_underway(div_operation_underway),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_accept(wb_accept), .timeout(timeout)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one operation in flight, aged from its issue edge
    bit          m_inflight = 0, m_op = 0, m_wbv = 0, m_tmo = 0;
    int          m_age = 0;
    logic [31:0] m_a = '0, m_b = '0, m_wbd = '0;
    logic [4:0]  m_rd = '0, m_wbr = '0;

    always @(posedge clock) begin
        if (!reset) begin
            m_inflight <= 0; m_op <= 0; m_wbv <= 0; m_tmo <= 0; m_age <= 0;
            m_a <= '0; m_b <= '0; m_wbd <= '0; m_rd <= '0; m_wbr <= '0;
        end else if (m_wbv) begin
            if (wb_accept) m_wbv <= 0;
        end else if (m_inflight) begin
            if (md_resultRDY) begin
                m_inflight <= 0;
                m_wbv      <= 1;
                m_wbd      <= md_exception ? (m_op ? 32'd5 : 32'd4) : md_result;
                m_wbr      <= md_exception ? 5'd30 : m_rd;
            end else if (m_age == MAXC) begin
                m_inflight <= 0;
                m_wbv      <= 1;
                m_wbd      <= m_op ? 32'd5 : 32'd4;
                m_wbr      <= 5'd30;
                m_tmo      <= 1;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (start_mult || start_div) begin
            m_inflight <= 1;
            m_age      <= 1;
            m_op       <= !start_mult;
            m_a        <= operand_A;
            m_b        <= operand_B;
            m_rd       <= rd_in;
        end
    end

    always @(negedge clock) begin
        bit busy;
        if (chk_en) begin
            busy = m_inflight || m_wbv;
            check("md_ctrl_MULT", md_ctrl_MULT, m_inflight && m_age == 1 && !m_op);
            check("md_ctrl_DIV", md_ctrl_DIV, m_inflight && m_age == 1 && m_op);
            check("md_operand_A", md_operand_A, m_a);
            check("md_operand_B", md_operand_B, m_b);
            check("wb_valid", wb_valid, m_wbv);
            check("timeout", timeout, m_tmo);
            check("mult_underway", mult_operation_underway,
                  (busy && !m_op) || (!busy && start_mult));
            check("div_underway", div_operation_underway,
                  (busy && m_op) || (!busy && start_div && !start_mult));
            if (m_wbv) begin
                check("wb_data", wb_data, m_wbd);
                check("wb_rd", wb_rd, m_wbr);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        start_mult = m; start_div = d;
        operand_A = a; operand_B = b; rd_in = rd;
        tick();
        start_mult = 0; start_div = 0;
    endtask

    task automatic ready(input logic [31:0] res, input bit exc);
        md_result = res; md_exception = exc; md_resultRDY = 1;
        tick();
        md_resultRDY = 0; md_exception = 0;
    endtask

    task automatic retire();
        wb_accept = 1;
        tick();
        wb_accept = 0;
    endtask

    task automatic wait_wb(input int bound);
        int i;
        i = 0;
        while (!wb_valid && i < bound) begin
            tick();
            i++;
        end
        check("wb_wait", wb_valid, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        reset = 0;
        tick_n(3);
        chk_en = 1;
        check("rst_wb_valid", wb_valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_operand_A", md_operand_A, 0);
        check("rst_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 0);
        reset = 1;
        tick();

        // Mult, ready at cycle 33
        issue(1, 0, 32'd6, 32'd7, 5'd3);
        check("mult_pulse_c1", md_ctrl_MULT, 1);
        tick_n(32);
        ready(32'd42, 0);
        check("mult_wb_valid", wb_valid, 1);
        check("mult_wb_data", wb_data, 32'd42);
        check("mult_wb_rd", wb_rd, 5'd3);
        wb_accept = 1;
        #1;
        check("mult_underway_accept", mult_operation_underway, 1);
        tick();
        wb_accept = 0;
        check("mult_underway_drop", mult_operation_underway, 0);

        // Divide by zero raising an exception at cycle 5
        issue(0, 1, 32'd100, 32'd0, 5'd7);
        tick_n(4);
        ready(32'hffff_ffff, 1);
        check("dz_wb_data", wb_data, 32'd5);
        check("dz_wb_rd", wb_rd, 5'd30);
        check("dz_timeout", timeout, 0);
        check("dz_underway", div_operation_underway, 1);
        retire();

        // Timeout, then a ready on the would-be timeout cycle
        issue(1, 0, 32'd1, 32'd1, 5'd2);
        tick_n(39);
        check("to_not_yet", wb_valid, 0);
        tick();
        check("to_wb_valid", wb_valid, 1);
        check("to_wb_data", wb_data, 32'd4);
        check("to_wb_rd", wb_rd, 5'd30);
        check("to_flag", timeout, 1);
        retire();
        check("to_sticky", timeout, 1);
        issue(1, 0, 32'd9, 32'd9, 5'd12);
        tick_n(39);
        ready(32'd81, 0);
        check("to2_wb_data", wb_data, 32'd81);
        check("to2_wb_rd", wb_rd, 5'd12);
        check("to2_flag", timeout, 1);
        retire();

        // Writeback backpressure then back-to-back issue
        issue(0, 1, 32'd50, 32'd5, 5'd9);
        tick_n(2);
        ready(32'd10, 0);
        tick_n(10);
        check("bp_wb_data", wb_data, 32'd10);
        check("bp_wb_valid", wb_valid, 1);
        check("bp_underway", div_operation_underway, 1);
        retire();
        check("bp_idle", wb_valid, 0);
        issue(1, 0, 32'd1, 32'd2, 5'd4);
        check("b2b_pulse", md_ctrl_MULT, 1);
        ready(32'd2, 0);
        retire();

        // Simultaneous starts, then a stray DIV while busy
        start_mult = 1; start_div = 1; operand_A = 32'd11; operand_B = 32'd13; rd_in = 5'd6;
        #1;
        check("sim_mult_uw", mult_operation_underway, 1);
        check("sim_div_uw", div_operation_underway, 0);
        tick();
        start_mult = 0; start_div = 0;
        check("sim_ctrl_mult", md_ctrl_MULT, 1);
        check("sim_ctrl_div", md_ctrl_DIV, 0);
        start_div = 1; operand_A = 32'hdead_beef; operand_B = 32'h1234; rd_in = 5'd1;
        tick();
        start_div = 0;
        check("stray_opA", md_operand_A, 32'd11);
        check("stray_ctrl_div", md_ctrl_DIV, 0);
        check("stray_div_uw", div_operation_underway, 0);
        ready(32'd143, 0);
        check("stray_wb_rd", wb_rd, 5'd6);
        retire();

        // Reset at BUSY cycle 10, late ready at cycle 15
        issue(0, 1, 32'd77, 32'd3, 5'd11);
        tick_n(9);
        reset = 0;
        tick();
        reset = 1;
        check("rmid_opA", md_operand_A, 0);
        check("rmid_timeout", timeout, 0);
        check("rmid_div_uw", div_operation_underway, 0);
        tick_n(4);
        ready(32'd25, 0);
        check("rmid_no_wb", wb_valid, 0);
        tick();

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            int sel, lat, dly;
            bit exc;
            a = $urandom; b = $urandom;
            sel = $urandom_range(0, 3);
            lat = $urandom_range(1, 44);
            exc = ($urandom_range(0, 3) == 0);
            issue(sel <= 1 || sel == 3, sel >= 2, a, b, 5'($urandom_range(0, 31)));
            for (int c = 1; c <= lat && !wb_valid; c++) begin
                if (c == lat) begin
                    md_resultRDY = 1; md_exception = exc; md_result = $urandom;
                end
                if ($urandom_range(0, 7) == 0) begin
                    start_mult = $urandom_range(0, 1); start_div = 1;
                    operand_A = $urandom; operand_B = $urandom; rd_in = 5'($urandom_range(0, 31));
                end
                tick();
                md_resultRDY = 0; md_exception = 0; start_mult = 0; start_div = 0;
            end
            wait_wb(5);
            dly = $urandom_range(0, 3);
            tick_n(dly);
            retire();
            dly = $urandom_range(0, 2);
            for (int g = 0; g < dly; g++) begin
                md_resultRDY = $urandom_range(0, 1);
                tick();
                md_resultRDY = 0;
            end
        end

        tick_n(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
